// File: rtl/addsub_arbiter.sv
// Round-robin front end that shares one registered adder/subtractor
// among NREQ requesters and routes each result back to its owner.
module addsub_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int LAT   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_add,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_s,
    output logic                    AS_CE,
    output logic                    AS_ADD,
    output logic [WIDTH-1:0]        AS_A,
    output logic [WIDTH-1:0]        AS_B,
    input  logic [WIDTH-1:0]        AS_S,
    output logic                    busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef logic [IDW-1:0] id_t;

    typedef struct packed {
        logic             vld;
        logic             add;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        id_t              id;
    } issue_t;

    typedef struct packed {
        logic vld;
        id_t  id;
    } tag_t;

    issue_t          issue_q, issue_d;
    tag_t            tag_q [LAT];
    tag_t            tag_d [LAT];
    id_t             last_grant_q, last_grant_d;
    logic [NREQ-1:0] grant;
    id_t             gnt_id;
    logic            xfer;

    // Search starts one past the last winner and wraps.
    always_comb begin
        int idx;
        grant  = '0;
        gnt_id = '0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant_q) + k) % NREQ;
            if (grant == '0 && req_valid[idx]) begin
                grant[idx] = 1'b1;
                gnt_id     = id_t'(idx);
            end
        end
    end

    assign req_ready = (en && !RST) ? grant : '0;
    assign xfer      = |req_ready;

    always_comb begin
        issue_d = '0;
        if (xfer) begin
            issue_d.vld = 1'b1;
            issue_d.add = req_add[gnt_id];
            issue_d.a   = req_a[int'(gnt_id)*WIDTH +: WIDTH];
            issue_d.b   = req_b[int'(gnt_id)*WIDTH +: WIDTH];
            issue_d.id  = gnt_id;
        end
        last_grant_d = xfer ? gnt_id : last_grant_q;
        tag_d[0].vld = issue_q.vld;
        tag_d[0].id  = issue_q.id;
        for (int j = 1; j < LAT; j++) begin
            tag_d[j] = tag_q[j-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            issue_q      <= '0;
            last_grant_q <= id_t'(NREQ - 1);
            for (int j = 0; j < LAT; j++) begin
                tag_q[j] <= '0;
            end
        end else begin
            issue_q      <= issue_d;
            last_grant_q <= last_grant_d;
            for (int j = 0; j < LAT; j++) begin
                tag_q[j] <= tag_d[j];
            end
        end
    end

    // Idle issue stage is all zeros, so the shared unit sees 0 operands.
    assign AS_CE  = issue_q.vld;
    assign AS_ADD = issue_q.add;
    assign AS_A   = issue_q.a;
    assign AS_B   = issue_q.b;
    assign rsp_s  = AS_S;

    always_comb begin
        rsp_valid = '0;
        if (tag_q[LAT-1].vld) begin
            rsp_valid[tag_q[LAT-1].id] = 1'b1;
        end
        busy = issue_q.vld;
        for (int j = 0; j < LAT; j++) begin
            busy = busy | tag_q[j].vld;
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed table, corner sequences and a
// random run against a transaction-level round-robin model.
module tb_addsub_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int LAT = 1;

    logic           CLK = 1'b0;
    logic           RST;
    logic           en;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_add;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_s;
    logic           AS_CE;
    logic           AS_ADD;
    logic [W-1:0]   AS_A;
    logic [W-1:0]   AS_B;
    logic [W-1:0]   AS_S;
    logic           busy;

    addsub_arbiter #(.WIDTH(W), .NREQ(N), .LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_add(req_add), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_s(rsp_s),
        .AS_CE(AS_CE), .AS_ADD(AS_ADD), .AS_A(AS_A), .AS_B(AS_B),
        .AS_S(AS_S), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Shared registered adder/subtractor, one cycle of latency.
    logic [W-1:0] s_reg;
    always_ff @(posedge CLK) begin
        if (AS_CE) s_reg <= AS_ADD ? AS_A + AS_B : AS_A - AS_B;
        else       s_reg <= '0;
    end
    assign AS_S = s_reg;

    typedef struct {
        int           id;
        logic [W-1:0] res;
        int           due;
    } exp_t;

    exp_t q[$];
    int   ptr;
    int   cyc;
    int   checks;
    int   failures;
    int   last_gnt;
    logic [N-1:0] cap_rsp_valid;
    logic [W-1:0] cap_rsp_s;
    logic         cap_busy;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] opa(input int i);
        return req_a[i*W +: W];
    endfunction

    function automatic logic [W-1:0] opb(input int i);
        return req_b[i*W +: W];
    endfunction

    // One cycle: check outputs mid-cycle against the model, then advance.
    task automatic step();
        logic [N-1:0] eg, ev;
        logic [W-1:0] es;
        logic         eb, ece;
        int           gid;
        exp_t         e;
        @(negedge CLK);
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        eg  = '0;
        gid = -1;
        if (!RST && en) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (ptr + k) % N;
                if (gid < 0 && req_valid[i]) gid = i;
            end
        end
        if (gid >= 0) eg[gid] = 1'b1;
        ev  = '0;
        es  = '0;
        eb  = 1'b0;
        ece = 1'b0;
        foreach (q[j]) begin
            if (q[j].due == cyc) begin
                ev[q[j].id] = 1'b1;
                es          = q[j].res;
            end
            if (q[j].due >= cyc) eb = 1'b1;
            if (q[j].due == cyc + 1) ece = 1'b1;
        end
        cap_rsp_valid = rsp_valid;
        cap_rsp_s     = rsp_s;
        cap_busy      = busy;
        chk("req_ready", 64'(req_ready), 64'(eg));
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        if (ev != '0) chk("rsp_s", 64'(rsp_s), 64'(es));
        chk("busy", 64'(busy), 64'(eb));
        chk("as_ce", 64'(AS_CE), 64'(ece));
        last_gnt = gid;
        if (gid >= 0) begin
            e.id  = gid;
            e.res = req_add[gid] ? opa(gid) + opb(gid) : opa(gid) - opb(gid);
            e.due = cyc + 1 + LAT;
            q.push_back(e);
            ptr = gid;
        end
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        q.delete();
        ptr = N - 1;
        #1;
        chk("rst_as_a", 64'(AS_A), 64'd0);
        chk("rst_as_b", 64'(AS_B), 64'd0);
        chk("rst_as_add", 64'(AS_ADD), 64'd0);
        step();
        RST = 1'b0;
    endtask

    task automatic set_op(input int i, input logic add,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        req_add[i]     = add;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    typedef struct {
        int           id;
        logic         add;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
    } vec_t;

    vec_t vecs[6];

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        ptr       = N - 1;
        RST       = 1'b1;
        en        = 1'b1;
        req_valid = '1;
        req_add   = '0;
        req_a     = '0;
        req_b     = '0;

        vecs[0] = '{2, 1'b1, 32'd5,          32'hFFFF_FFF9, 32'hFFFF_FFFE};
        vecs[1] = '{0, 1'b0, 32'h8000_0000,  32'd1,         32'h7FFF_FFFF};
        vecs[2] = '{1, 1'b1, 32'h7FFF_FFFF,  32'd1,         32'h8000_0000};
        vecs[3] = '{3, 1'b0, 32'd5,          32'd7,         32'hFFFF_FFFE};
        vecs[4] = '{2, 1'b0, 32'd0,          32'd0,         32'd0};
        vecs[5] = '{1, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};

        do_reset();
        req_valid = '0;
        step();

        for (int v = 0; v < 6; v++) begin
            set_op(vecs[v].id, vecs[v].add, vecs[v].a, vecs[v].b);
            req_valid = N'(1) << vecs[v].id;
            step();
            chk("vec_grant", 64'(last_gnt), 64'(vecs[v].id));
            req_valid = '0;
            step();
            step();
            chk("vec_rsp_valid", 64'(cap_rsp_valid), 64'(N'(1) << vecs[v].id));
            chk("vec_rsp_s", 64'(cap_rsp_s), 64'(vecs[v].s));
        end

        // Four requesters valid continuously.
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, i[0], W'(100 * (i + 1)), W'(i + 3));
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_order", 64'(last_gnt), 64'(k % N));
        end
        req_valid = '0;
        step();
        step();
        step();

        // Enable dropped after the first grant.
        do_reset();
        set_op(1, 1'b1, 32'd10, 32'd20);
        set_op(3, 1'b0, 32'd10, 32'd20);
        req_valid = 4'b1010;
        step();
        chk("en_first", 64'(last_gnt), 64'd1);
        en = 1'b0;
        step();
        chk("en_hold", 64'(last_gnt), 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("en_rsp", 64'(cap_rsp_valid), 64'b0010);
        chk("en_rsp_s", 64'(cap_rsp_s), 64'd30);
        step();
        chk("en_busy_low", 64'(cap_busy), 64'd0);
        en = 1'b1;
        step();
        chk("en_next", 64'(last_gnt), 64'd3);
        req_valid = '0;
        step();
        step();
        step();

        // Reset one cycle after a grant.
        set_op(2, 1'b1, 32'd1, 32'd2);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_no_rsp", 64'(cap_rsp_valid), 64'd0);
        end
        req_valid = 4'b0110;
        step();
        chk("rst_ptr", 64'(last_gnt), 64'd1);
        req_valid = '1;
        step();
        chk("rst_ptr2", 64'(last_gnt), 64'd2);
        req_valid = '0;
        step();
        step();

        do_reset();
        req_valid = '1;
        step();
        chk("rst_first_0", 64'(last_gnt), 64'd0);
        req_valid = '0;

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom);
            req_add   = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = $urandom;
                req_b[i*W +: W] = $urandom;
            end
            en = ($urandom % 6) != 0;
            step();
        end
        req_valid = '0;
        en        = 1'b1;
        for (int k = 0; k < 4; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
